// File: rtl/demux_4_32_pipe_pkg.sv
// demux_4_32_pipe_pkg: shared channel codes, slot state encoding and select decode.
package demux_4_32_pipe_pkg;

    localparam int NCH = 4;

    typedef enum logic [1:0] {
        CH0 = 2'd0,
        CH1 = 2'd1,
        CH2 = 2'd2,
        CH3 = 2'd3
    } ch_e;

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } slot_state_e;

    function automatic logic [NCH-1:0] sel_onehot(input logic [1:0] sel);
        return {sel == CH3, sel == CH2, sel == CH1, sel == CH0};
    endfunction

endpackage

// File: rtl/demux_4_32_pipe_if.sv
// demux_4_32_pipe_if: input valid/ready/sel/data bus plus four output slot handshakes.
interface demux_4_32_pipe_if #(
    parameter int WIDTH = 32
);
    import demux_4_32_pipe_pkg::*;

    logic                      in_valid;
    logic                      in_ready;
    logic [1:0]                in_sel;
    logic [WIDTH-1:0]          in_data;
    logic [NCH-1:0]            out_valid;
    logic [NCH-1:0]            out_ready;
    logic [NCH-1:0][WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_sel, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_sel, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/demux_4_32_pipe_slot.sv
// demux_slot: one-entry FIFO slot; a fill always wins over a drain in the same cycle.
module demux_slot
    import demux_4_32_pipe_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fill_i,
    input  logic [WIDTH-1:0] fill_data_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    slot_state_e      state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    // Fill is only ever offered when the slot is empty or draining this cycle.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        if (fill_i) begin
            state_d = S_FULL;
            data_d  = fill_data_i;
        end else if (state_q == S_FULL && ready_i) begin
            state_d = S_EMPTY;
        end
    end

    assign valid_o = (state_q == S_FULL);
    assign data_o  = data_q;

endmodule

// File: rtl/demux_4_32_pipe.sv
// demux_4_32_pipe: registered 1-to-4 demux with a one-word slot per channel.
// Optional per-channel saturating drain counters on stat_cnt_o when DEMUX_STATS_EN is defined.
module demux_4_32_pipe
    import demux_4_32_pipe_pkg::*;
#(
    parameter int WIDTH = 32
`ifdef DEMUX_STATS_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic                    clk,
    input  logic                    rst,
    demux_4_32_pipe_if.slave        bus
`ifdef DEMUX_STATS_EN
    ,
    output logic [NCH*CNT_W-1:0]    stat_cnt_o
`endif
);

    logic [NCH-1:0]            fill;
    logic [NCH-1:0]            valid;
    logic [NCH-1:0][WIDTH-1:0] data;
    logic                      in_ready;

    // Only the selected channel can stall the input; out_ready passes straight through.
    assign in_ready      = ~valid[bus.in_sel] | bus.out_ready[bus.in_sel];
    assign fill          = (bus.in_valid & in_ready) ? sel_onehot(bus.in_sel) : '0;
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = valid;
    assign bus.out_data  = data;

    for (genvar i = 0; i < NCH; i++) begin : g_slot
        demux_slot #(.WIDTH(WIDTH)) u_slot (
            .clk         (clk),
            .rst         (rst),
            .fill_i      (fill[i]),
            .fill_data_i (bus.in_data),
            .ready_i     (bus.out_ready[i]),
            .valid_o     (valid[i]),
            .data_o      (data[i])
        );
    end

`ifdef DEMUX_STATS_EN
    logic [NCH-1:0]            drain;
    logic [NCH-1:0][CNT_W-1:0] cnt_q, cnt_d;

    assign drain = valid & bus.out_ready;

    always_comb begin
        cnt_d = cnt_q;
        for (int c = 0; c < NCH; c++)
            cnt_d[c] = (drain[c] && cnt_q[c] != '1) ? cnt_q[c] + CNT_W'(1) : cnt_q[c];
    end

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign stat_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_demux_4_32_pipe.sv
// tb_demux_4_32_pipe: directed scenarios plus randomized traffic against a per-channel buffer model.
module tb_demux_4_32_pipe;

`ifdef DEMUX_STATS_EN
    localparam int CNT_W = 4;
    logic [4*CNT_W-1:0] stat;
`endif

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    bit          m_full [4];
    logic [31:0] m_data [4];
    int          m_cnt  [4];

    demux_4_32_pipe_if #(.WIDTH(32)) bus ();

    demux_4_32_pipe #(
        .WIDTH(32)
`ifdef DEMUX_STATS_EN
        , .CNT_W(CNT_W)
`endif
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef DEMUX_STATS_EN
        , .stat_cnt_o (stat)
`endif
    );

    always #5 clk = ~clk;

    // Model: each channel is a buffer holding at most one word; drains precede the fill.
    task automatic step();
        bit acc;
        int s;
        s   = int'(bus.in_sel);
        acc = bus.in_valid && (!m_full[s] || bus.out_ready[s]);
        @(posedge clk);
        if (rst) begin
            for (int c = 0; c < 4; c++) begin
                m_full[c] = 0;
                m_data[c] = '0;
                m_cnt[c]  = 0;
            end
        end else begin
            for (int c = 0; c < 4; c++)
                if (m_full[c] && bus.out_ready[c]) begin
                    m_full[c] = 0;
                    m_cnt[c]  = m_cnt[c] + 1;
                end
            if (acc) begin
                m_full[s] = 1;
                m_data[s] = bus.in_data;
            end
        end
        #1;
    endtask

    task automatic send(input logic [1:0] sel, input logic [31:0] d);
        bus.in_valid = 1'b1;
        bus.in_sel   = sel;
        bus.in_data  = d;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_sel    = 2'd0;
        bus.in_data   = '0;
        bus.out_ready = 4'h0;
        step();
        step();
        rst = 1'b0;
        #1;
        n_cmp++;
        if (bus.out_valid !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_valid got=%b want=0000", bus.out_valid);
        end
        for (int c = 0; c < 4; c++) begin
            n_cmp++;
            if (bus.out_data[c] !== 32'h0) begin
                n_bad++;
                $display("FAIL reset_data%0d got=%h want=0", c, bus.out_data[c]);
            end
        end
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_in_ready got=%b want=1", bus.in_ready);
        end
    endtask

    task automatic test_basic_route();
        bus.out_ready = 4'hF;
        send(2'd0, 32'h11111111);
        #1;
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL route_in_ready got=%b want=1", bus.in_ready);
        end
        step();
        n_cmp++;
        if (bus.out_valid !== 4'b0001 || bus.out_data[0] !== 32'h11111111) begin
            n_bad++;
            $display("FAIL route_ch0 valid=%b data=%h want 0001/11111111", bus.out_valid, bus.out_data[0]);
        end
        send(2'd3, 32'h22222222);
        step();
        n_cmp++;
        if (bus.out_valid !== 4'b1000 || bus.out_data[3] !== 32'h22222222) begin
            n_bad++;
            $display("FAIL route_ch3 valid=%b data=%h want 1000/22222222", bus.out_valid, bus.out_data[3]);
        end
        bus.in_valid = 1'b0;
        step();
        n_cmp++;
        if (bus.out_valid !== 4'b0000) begin
            n_bad++;
            $display("FAIL route_drain got=%b want=0000", bus.out_valid);
        end
    endtask

    task automatic test_stall_refill();
        bus.out_ready = 4'h0;
        send(2'd1, 32'hA);
        step();
        send(2'd1, 32'hB);
        #1;
        n_cmp++;
        if (bus.in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL stall_in_ready got=%b want=0", bus.in_ready);
        end
        step();
        n_cmp++;
        if (bus.out_valid !== 4'b0010 || bus.out_data[1] !== 32'hA) begin
            n_bad++;
            $display("FAIL stall_hold valid=%b data=%h want 0010/a", bus.out_valid, bus.out_data[1]);
        end
        bus.out_ready = 4'b0010;
        #1;
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL refill_in_ready got=%b want=1", bus.in_ready);
        end
        step();
        n_cmp++;
        if (bus.out_valid !== 4'b0010 || bus.out_data[1] !== 32'hB) begin
            n_bad++;
            $display("FAIL refill valid=%b data=%h want 0010/b", bus.out_valid, bus.out_data[1]);
        end
        bus.in_valid = 1'b0;
        step();
        bus.out_ready = 4'h0;
        n_cmp++;
        if (bus.out_valid !== 4'b0000) begin
            n_bad++;
            $display("FAIL refill_drain got=%b want=0000", bus.out_valid);
        end
    endtask

    task automatic test_independent();
        send(2'd2, 32'hD);
        step();
        send(2'd0, 32'hC);
        #1;
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL indep_in_ready got=%b want=1", bus.in_ready);
        end
        step();
        n_cmp++;
        if (bus.out_valid !== 4'b0101 || bus.out_data[0] !== 32'hC || bus.out_data[2] !== 32'hD) begin
            n_bad++;
            $display("FAIL indep valid=%b d0=%h d2=%h want 0101/c/d", bus.out_valid, bus.out_data[0], bus.out_data[2]);
        end
    endtask

    task automatic test_drain_all();
        send(2'd1, 32'h1);
        step();
        send(2'd3, 32'h3);
        step();
        n_cmp++;
        if (bus.out_valid !== 4'b1111) begin
            n_bad++;
            $display("FAIL all_full got=%b want=1111", bus.out_valid);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 4'hF;
        step();
        bus.out_ready = 4'h0;
        n_cmp++;
        if (bus.out_valid !== 4'b0000) begin
            n_bad++;
            $display("FAIL drain_all got=%b want=0000", bus.out_valid);
        end
    endtask

    task automatic test_reset_midflight();
        send(2'd1, 32'h5A5A0001);
        step();
        send(2'd3, 32'h5A5A0003);
        step();
        rst = 1'b1;
        send(2'd2, 32'h5A5A0002);
        step();
        rst = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        n_cmp++;
        if (bus.out_valid !== 4'b0000 || bus.out_data !== '0) begin
            n_bad++;
            $display("FAIL rst_mid valid=%b data=%h want 0/0", bus.out_valid, bus.out_data);
        end
        step();
        n_cmp++;
        if (bus.out_valid !== 4'b0000) begin
            n_bad++;
            $display("FAIL rst_no_deliver got=%b want=0000", bus.out_valid);
        end
    endtask

`ifdef DEMUX_STATS_EN
    task automatic test_stats();
        logic [15:0] want;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        step();
        rst = 1'b0;
        bus.out_ready = 4'hF;
        for (int i = 0; i < 28; i++) begin
            send(i < 20 ? 2'd2 : (i < 23 ? 2'd0 : 2'd3), 32'(i));
            step();
        end
        bus.in_valid = 1'b0;
        step();
        want = {4'd5, 4'hF, 4'd0, 4'd3};
        n_cmp++;
        if (stat !== want) begin
            n_bad++;
            $display("FAIL stats_sat got=%h want=%h", stat, want);
        end
    endtask
`endif

    task automatic test_random();
        logic [3:0] exp_v;
        for (int n = 0; n < 400; n++) begin
            rst           = ($urandom_range(0, 59) == 0);
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_sel    = 2'($urandom_range(0, 3));
            bus.in_data   = $urandom;
            bus.out_ready = 4'($urandom);
            #1;
            n_cmp++;
            if (bus.in_ready !== (!m_full[bus.in_sel] || bus.out_ready[bus.in_sel])) begin
                n_bad++;
                $display("FAIL rnd_in_ready cyc=%0d got=%b want=%b", n, bus.in_ready, !m_full[bus.in_sel] || bus.out_ready[bus.in_sel]);
            end
            step();
            exp_v = {m_full[3], m_full[2], m_full[1], m_full[0]};
            n_cmp++;
            if (bus.out_valid !== exp_v) begin
                n_bad++;
                $display("FAIL rnd_valid cyc=%0d got=%b want=%b", n, bus.out_valid, exp_v);
            end
            for (int c = 0; c < 4; c++)
                if (m_full[c]) begin
                    n_cmp++;
                    if (bus.out_data[c] !== m_data[c]) begin
                        n_bad++;
                        $display("FAIL rnd_data%0d cyc=%0d got=%h want=%h", c, n, bus.out_data[c], m_data[c]);
                    end
                end
`ifdef DEMUX_STATS_EN
            for (int c = 0; c < 4; c++) begin
                n_cmp++;
                if (int'(stat[c*CNT_W +: CNT_W]) !== (m_cnt[c] > 15 ? 15 : m_cnt[c])) begin
                    n_bad++;
                    $display("FAIL rnd_cnt%0d cyc=%0d got=%0d want=%0d", c, n, stat[c*CNT_W +: CNT_W], m_cnt[c] > 15 ? 15 : m_cnt[c]);
                end
            end
`endif
        end
        rst = 1'b0;
        bus.in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic_route();
        test_stall_refill();
        test_independent();
        test_drain_all();
        test_reset_midflight();
`ifdef DEMUX_STATS_EN
        test_stats();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
